// File: rtl/uart_cmd_parser.sv
// Packet parser: 4-byte header, then payload is echoed, packed into
// 32-bit operand words, or drained. Stalled packets abort on timeout.
module uart_cmd_parser #(
    parameter logic [7:0]  EchoOp        = 8'hEC,
    parameter logic [7:0]  AddOp         = 8'hA1,
    parameter logic [7:0]  MulOp         = 8'hB1,
    parameter logic [7:0]  DivOp         = 8'hB2,
    parameter int unsigned TimeoutCycles = 28000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [7:0]  echo_data_o,
    output logic        echo_valid_o,
    input  logic        echo_ready_i,
    output logic [31:0] word_data_o,
    output logic [7:0]  word_op_o,
    output logic        word_last_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        err_o,
    output logic        busy_o
);
    localparam int TW = $clog2(TimeoutCycles);

    typedef enum logic [2:0] {
        S_OP, S_RSV, S_LLO, S_LHI, S_ECHO, S_WORD, S_WOUT, S_DRAIN
    } state_t;

    state_t        state;
    logic [7:0]    opcode;
    logic [7:0]    len_lo;
    logic [15:0]   remaining;
    logic [1:0]    idx;
    logic [TW-1:0] tcnt;
    logic [31:0]   shreg;
    logic          drain_err;

    logic          is_arith;
    logic          timed;
    logic          tmo;
    logic          base_ready;
    logic          take;
    logic [15:0]   len_full;
    logic [15:0]   len_rem;

    assign is_arith = (opcode == AddOp) || (opcode == MulOp) ||
                      (opcode == DivOp);
    assign timed    = (state != S_OP) && (state != S_WOUT);
    assign tmo      = timed && (tcnt == TW'(TimeoutCycles - 1));
    assign len_full = {in_data_i, len_lo};
    assign len_rem  = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;

    always_comb begin
        base_ready = 1'b1;
        unique case (state)
            S_ECHO:  base_ready = echo_ready_i;
            S_WOUT:  base_ready = 1'b0;
            default: base_ready = 1'b1;
        endcase
    end

    // A timeout owns the cycle: the pending byte is neither consumed nor echoed.
    assign in_ready_o   = base_ready && !tmo;
    assign take         = in_valid_i && in_ready_o;
    assign echo_valid_o = (state == S_ECHO) && in_valid_i && !tmo;
    assign echo_data_o  = (state == S_ECHO) ? in_data_i : 8'h00;
    assign busy_o       = (state != S_OP);
    assign word_data_o  = shreg;
    assign word_op_o    = opcode;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_OP;
            opcode       <= 8'h00;
            len_lo       <= 8'h00;
            remaining    <= 16'd0;
            idx          <= 2'd0;
            tcnt         <= '0;
            shreg        <= 32'd0;
            drain_err    <= 1'b0;
            word_valid_o <= 1'b0;
            word_last_o  <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (state == S_OP || take) begin
                tcnt <= '0;
            end else if (timed && !in_valid_i) begin
                tcnt <= tcnt + 1'b1;
            end
            if (tmo) begin
                err_o     <= 1'b1;
                state     <= S_OP;
                idx       <= 2'd0;
                tcnt      <= '0;
                drain_err <= 1'b0;
            end else begin
                unique case (state)
                    S_OP: if (take) begin
                        opcode <= in_data_i;
                        state  <= S_RSV;
                    end
                    S_RSV: if (take) state <= S_LLO;
                    S_LLO: if (take) begin
                        len_lo <= in_data_i;
                        state  <= S_LHI;
                    end
                    S_LHI: if (take) begin
                        remaining <= len_rem;
                        idx       <= 2'd0;
                        drain_err <= 1'b0;
                        if (len_rem == 16'd0) begin
                            err_o <= is_arith;
                            state <= S_OP;
                        end else if (opcode == EchoOp) begin
                            state <= S_ECHO;
                        end else if (is_arith) begin
                            state <= S_WORD;
                        end else begin
                            err_o <= 1'b1;
                            state <= S_DRAIN;
                        end
                    end
                    S_ECHO: if (take) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) state <= S_OP;
                    end
                    S_WORD: if (take) begin
                        shreg[{idx, 3'b000} +: 8] <= in_data_i;
                        remaining <= remaining - 16'd1;
                        if (idx == 2'd3) begin
                            state        <= S_WOUT;
                            word_valid_o <= 1'b1;
                            word_last_o  <= (remaining - 16'd1) < 16'd4;
                            idx          <= 2'd0;
                        end else if (remaining == 16'd1) begin
                            err_o <= 1'b1;
                            state <= S_OP;
                            idx   <= 2'd0;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                    S_WOUT: if (word_ready_i) begin
                        word_valid_o <= 1'b0;
                        word_last_o  <= 1'b0;
                        if (remaining == 16'd0) begin
                            state <= S_OP;
                        end else if (remaining < 16'd4) begin
                            drain_err <= 1'b1;
                            state     <= S_DRAIN;
                        end else begin
                            state <= S_WORD;
                        end
                    end
                    S_DRAIN: if (take) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            err_o     <= drain_err;
                            drain_err <= 1'b0;
                            state     <= S_OP;
                        end
                    end
                    default: state <= S_OP;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed per-cycle vector bench for uart_cmd_parser plus hand-written
// timeout and mid-packet reset sequences.
module tb_uart_cmd_parser;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  echo_data;
    logic        echo_valid;
    logic        echo_ready = 1'b0;
    logic [31:0] word_data;
    logic [7:0]  word_op;
    logic        word_last;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        err;
    logic        busy;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_cmd_parser dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .echo_data_o  (echo_data),
        .echo_valid_o (echo_valid),
        .echo_ready_i (echo_ready),
        .word_data_o  (word_data),
        .word_op_o    (word_op),
        .word_last_o  (word_last),
        .word_valid_o (word_valid),
        .word_ready_i (word_ready),
        .err_o        (err),
        .busy_o       (busy)
    );

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        er;
        logic        wr;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic        wv;
        logic [31:0] wd;
        logic [7:0]  wop;
        logic        wl;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic p(input logic [7:0] d, input logic v, input logic er,
                     input logic wr, input logic rdy, input logic ev,
                     input logic [7:0] ed, input logic wv,
                     input logic [31:0] wd, input logic [7:0] wop,
                     input logic wl, input logic e, input logic b);
        vec_t x;
        x.d = d; x.v = v; x.er = er; x.wr = wr; x.rdy = rdy;
        x.ev = ev; x.ed = ed; x.wv = wv; x.wd = wd; x.wop = wop;
        x.wl = wl; x.err = e; x.busy = b;
        tbl.push_back(x);
    endtask

    task automatic hdr(input logic [7:0] op, input logic [7:0] lo);
        p(op,    1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        p(8'h00, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        p(lo,    1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        p(8'h00, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic idle(input logic e, input logic b);
        p(8'h00, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, e, b);
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            in_data    = tbl[i].d;
            in_valid   = tbl[i].v;
            echo_ready = tbl[i].er;
            word_ready = tbl[i].wr;
            @(negedge clk);
            chk({tag, ".in_ready"}, 32'(in_ready), 32'(tbl[i].rdy));
            chk({tag, ".echo_valid"}, 32'(echo_valid), 32'(tbl[i].ev));
            if (tbl[i].ev)
                chk({tag, ".echo_data"}, 32'(echo_data), 32'(tbl[i].ed));
            chk({tag, ".word_valid"}, 32'(word_valid), 32'(tbl[i].wv));
            if (tbl[i].wv) begin
                chk({tag, ".word_data"}, word_data, tbl[i].wd);
                chk({tag, ".word_op"}, 32'(word_op), 32'(tbl[i].wop));
                chk({tag, ".word_last"}, 32'(word_last), 32'(tbl[i].wl));
            end
            chk({tag, ".err"}, 32'(err), 32'(tbl[i].err));
            chk({tag, ".busy"}, 32'(busy), 32'(tbl[i].busy));
        end
        tbl.delete();
    endtask

    initial begin
        int n;
        bit seen;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("reset.in_ready", 32'(in_ready), 1);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.echo_valid", 32'(echo_valid), 0);
        chk("reset.word_valid", 32'(word_valid), 0);
        chk("reset.err", 32'(err), 0);

        hdr(8'hEC, 8'h07);
        p(8'h41, 1, 1, 0, 1, 1, 8'h41, 0, 0, 0, 0, 0, 1);
        p(8'h42, 1, 1, 0, 1, 1, 8'h42, 0, 0, 0, 0, 0, 1);
        p(8'h43, 1, 1, 0, 1, 1, 8'h43, 0, 0, 0, 0, 0, 1);
        idle(0, 0);
        run_tbl("echo");

        hdr(8'hEC, 8'h07);
        p(8'h41, 1, 1, 0, 1, 1, 8'h41, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            p(8'h42, 1, 0, 0, 0, 1, 8'h42, 0, 0, 0, 0, 0, 1);
        p(8'h42, 1, 1, 0, 1, 1, 8'h42, 0, 0, 0, 0, 0, 1);
        p(8'h43, 1, 1, 0, 1, 1, 8'h43, 0, 0, 0, 0, 0, 1);
        idle(0, 0);
        run_tbl("echo_bp");

        hdr(8'hA1, 8'h0C);
        p(8'h01, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            p(8'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            p(8'hFF, 1, 1, 0, 0, 0, 0, 1, 32'h1, 8'hA1, 0, 0, 1);
        p(8'hFF, 1, 1, 1, 0, 0, 0, 1, 32'h1, 8'hA1, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            p(8'hFF, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        p(8'h00, 0, 1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 8'hA1, 1, 0, 1);
        idle(0, 0);
        run_tbl("add");

        hdr(8'h7F, 8'h06);
        p(8'hAA, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        p(8'hBB, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0, 0);
        run_tbl("bad_op");

        hdr(8'hB1, 8'h06);
        p(8'h11, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        p(8'h22, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1, 0);
        idle(0, 0);
        run_tbl("mul_short");

        hdr(8'hB2, 8'h04);
        idle(1, 0);
        idle(0, 0);
        run_tbl("div_empty");

        hdr(8'hA1, 8'h08);
        p(8'h01, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        run_tbl("tmo_hdr");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30000) begin
            @(posedge clk);
            n++;
            #1;
            seen = err;
        end
        chk("timeout.cycles", 32'(n), 32'd28000);
        chk("timeout.busy", 32'(busy), 0);
        chk("timeout.word_valid", 32'(word_valid), 0);

        hdr(8'hEC, 8'h05);
        p(8'h55, 1, 1, 1, 1, 1, 8'h55, 0, 0, 0, 0, 0, 1);
        idle(0, 0);
        run_tbl("post_tmo");

        hdr(8'hA1, 8'h08);
        p(8'h01, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        run_tbl("rst_mid");
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid.in_ready", 32'(in_ready), 1);
        chk("rst_mid.busy", 32'(busy), 0);
        chk("rst_mid.word_valid", 32'(word_valid), 0);
        chk("rst_mid.word_data", word_data, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_ni = 1'b1;

        hdr(8'hEC, 8'h05);
        p(8'h66, 1, 1, 1, 1, 1, 8'h66, 0, 0, 0, 0, 0, 1);
        idle(0, 0);
        run_tbl("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", applied,
                 miscompares);
        $finish;
    end
endmodule
